// File: rtl/vga_capture_if.sv
// Sync/colour stream into the capture block and
// pixel write bus out of it towards the frame buffer.
interface vga_capture_if;
  logic        hs;
  logic        vs;
  logic [11:0] rgb;
  logic        wr_en;
  logic [9:0]  wr_x;
  logic [9:0]  wr_y;
  logic [11:0] wr_data;
  logic        frame_start;

  modport master (
    input  hs, vs, rgb,
    output wr_en, wr_x, wr_y, wr_data, frame_start
  );

  modport slave (
    output hs, vs, rgb,
    input  wr_en, wr_x, wr_y, wr_data, frame_start
  );
endinterface

// File: rtl/vga_capture.sv
// VGA receiver: recovers pixel coordinates from sync edges,
// locks after one clean frame and emits per-pixel writes.
module vga_capture #(
  parameter int H_TOTAL  = 800,
  parameter int H_LEFT   = 144,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_TOP    = 35,
  parameter int V_ACTIVE = 480
) (
  input  logic          clk,
  input  logic          rstn,
  vga_capture_if.master bus,
  output logic          locked,
  output logic [9:0]    h_last,
  output logic [9:0]    v_last,
  output logic [7:0]    err_cnt
);

  localparam logic [9:0] HT1 = 10'(H_TOTAL - 1);
  localparam logic [9:0] HL  = 10'(H_LEFT);
  localparam logic [9:0] HE  = 10'(H_LEFT + H_ACTIVE);
  localparam logic [9:0] VT1 = 10'(V_TOTAL - 1);
  localparam logic [9:0] VTP = 10'(V_TOP);
  localparam logic [9:0] VE  = 10'(V_TOP + V_ACTIVE);
  localparam logic [9:0] SAT = 10'h3FF;

  typedef enum logic [1:0] {
    SEARCH,
    ALIGN,
    LOCKED
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        hs_r;
  logic        vs_r;
  logic [11:0] rgb_r;
  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic        hs_rise;
  logic        vs_rise;
  logic        e_line;
  logic        e_frame;
  logic        e_align;
  logic        e_stuck;
  logic        e_any;
  logic        cap;
  logic        cap_org;
  logic        err_inc;
  logic        locked_nx;

  assign hs_rise = bus.hs & ~hs_r;
  assign vs_rise = bus.vs & ~vs_r;
  assign e_line  = hs_rise && (hcnt != HT1);
  assign e_frame = vs_rise && (vcnt != VT1);
  assign e_align = vs_rise && !hs_rise;
  assign e_stuck = (hcnt == SAT);
  assign e_any   = e_line | e_frame | e_align | e_stuck;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= SEARCH;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      SEARCH: begin
        if (hs_rise && vs_rise) state_nx = ALIGN;
      end
      ALIGN: begin
        if (e_line || e_align || e_stuck) begin
          state_nx = SEARCH;
        end else if (hs_rise && vs_rise) begin
          state_nx = e_frame ? ALIGN : LOCKED;
        end
      end
      LOCKED: begin
        if (e_any) state_nx = SEARCH;
      end
      default: state_nx = SEARCH;
    endcase
  end

  // capture decisions use the state held before this edge
  always_comb begin
    cap = (state == LOCKED)
        && (hcnt >= HL) && (hcnt < HE)
        && (vcnt >= VTP) && (vcnt < VE);
    cap_org   = cap && (hcnt == HL) && (vcnt == VTP);
    err_inc   = (state == LOCKED) && e_any;
    locked_nx = (state_nx == LOCKED);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hs_r  <= 1'b0;
      vs_r  <= 1'b0;
      rgb_r <= 12'h000;
      hcnt  <= SAT;
      vcnt  <= SAT;
    end else begin
      hs_r  <= bus.hs;
      vs_r  <= bus.vs;
      rgb_r <= bus.rgb;
      if (hs_rise) begin
        hcnt <= 10'd0;
      end else if (hcnt != SAT) begin
        hcnt <= hcnt + 10'd1;
      end
      if (hs_rise) begin
        if (vs_rise) begin
          vcnt <= 10'd0;
        end else if (vcnt != SAT) begin
          vcnt <= vcnt + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_last  <= 10'd0;
      v_last  <= 10'd0;
      err_cnt <= 8'd0;
      locked  <= 1'b0;
    end else begin
      if (hs_rise) h_last <= hcnt;
      if (vs_rise) v_last <= vcnt;
      if (err_inc && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
      locked <= locked_nx;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.wr_en       <= 1'b0;
      bus.wr_x        <= SAT;
      bus.wr_y        <= SAT;
      bus.wr_data     <= 12'h000;
      bus.frame_start <= 1'b0;
    end else begin
      bus.wr_en       <= cap;
      bus.wr_x        <= cap ? hcnt - HL : SAT;
      bus.wr_y        <= cap ? vcnt - VTP : SAT;
      bus.wr_data     <= cap ? rgb_r : 12'h000;
      bus.frame_start <= cap_org;
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a reduced 24x12 raster
// with a 12x8 active window; model checked every cycle.
module tb_vga_capture;
  localparam int HT = 24;
  localparam int HL = 6;
  localparam int HA = 12;
  localparam int VT = 12;
  localparam int VP = 2;
  localparam int VA = 8;
  localparam int PIX = HA * VA;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       locked;
  logic [9:0] h_last;
  logic [9:0] v_last;
  logic [7:0] err_cnt;

  vga_capture_if vif();

  vga_capture #(
    .H_TOTAL(HT), .H_LEFT(HL), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_TOP(VP), .V_ACTIVE(VA)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(vif),
    .locked(locked),
    .h_last(h_last),
    .v_last(v_last),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int fs_cnt = 0;
  int fs_bad = 0;
  logic [11:0] pin_d = 12'hFFF;
  bit chk_en = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_pos = 1023;
  int m_line = 1023;
  int phase = 0;
  int m_err = 0;
  bit m_hs = 0;
  bit m_vs = 0;
  logic [11:0] m_rgb = 0;
  bit exp_en = 0;
  int exp_x = 1023;
  int exp_y = 1023;
  logic [11:0] exp_d = 0;
  bit exp_fs = 0;
  bit exp_lk = 0;
  int exp_hl = 0;
  int exp_vl = 0;

  task automatic model_reset();
    m_pos = 1023; m_line = 1023; phase = 0; m_err = 0;
    m_hs = 0; m_vs = 0; m_rgb = 0;
    exp_en = 0; exp_x = 1023; exp_y = 1023; exp_d = 0;
    exp_fs = 0; exp_lk = 0; exp_hl = 0; exp_vl = 0;
  endtask

  task automatic model_step();
    bit hr, vr, bl, bf, ma, st, act;
    int px, py;
    hr = vif.hs && !m_hs;
    vr = vif.vs && !m_vs;
    px = m_pos - HL;
    py = m_line - VP;
    act = (phase == 2) && px >= 0 && px < HA && py >= 0 && py < VA;
    exp_en = act;
    exp_x  = act ? px : 1023;
    exp_y  = act ? py : 1023;
    exp_d  = act ? m_rgb : 12'h000;
    exp_fs = act && px == 0 && py == 0;
    bl = hr && m_pos != HT - 1;
    bf = vr && m_line != VT - 1;
    ma = vr && !hr;
    st = m_pos == 1023;
    if (phase == 0) begin
      if (hr && vr) phase = 1;
    end else if (phase == 1) begin
      if (bl || ma || st) phase = 0;
      else if (hr && vr) phase = bf ? 1 : 2;
    end else if (bl || bf || ma || st) begin
      phase = 0;
      if (m_err < 255) m_err++;
    end
    if (hr) exp_hl = m_pos;
    if (vr) exp_vl = m_line;
    if (hr) begin
      m_line = vr ? 0 : (m_line < 1023 ? m_line + 1 : 1023);
      m_pos = 0;
    end else if (m_pos < 1023) begin
      m_pos++;
    end
    m_hs = vif.hs;
    m_vs = vif.vs;
    m_rgb = vif.rgb;
    exp_lk = phase == 2;
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("wr_en", 32'(vif.wr_en), 32'(exp_en));
      chk("wr_x", 32'(vif.wr_x), 32'(exp_x));
      chk("wr_y", 32'(vif.wr_y), 32'(exp_y));
      chk("wr_data", 32'(vif.wr_data), 32'(exp_d));
      chk("frame_start", 32'(vif.frame_start), 32'(exp_fs));
      chk("locked", 32'(locked), 32'(exp_lk));
      chk("h_last", 32'(h_last), 32'(exp_hl));
      chk("v_last", 32'(v_last), 32'(exp_vl));
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
      if (vif.wr_en) wr_cnt++;
      if (vif.frame_start) begin
        fs_cnt++;
        if (!vif.wr_en || vif.wr_x != 0 || vif.wr_y != 0) fs_bad++;
      end
      if (vif.wr_en && vif.wr_x == 10'd5 && vif.wr_y == 10'd3)
        pin_d = vif.wr_data;
    end
  end

  // ---------------- stream source ----------------
  int gx = 0;
  int gy = 0;
  int cur_len = HT;
  bit kill = 0;

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      logic [9:0] px, py;
      px = 10'(gx - HL);
      py = 10'(gy - VP);
      vif.hs = !kill && gx < 3;
      vif.vs = !kill && gy < 2;
      if (gx >= HL && gx < HL + HA && gy >= VP && gy < VP + VA)
        vif.rgb = {px[3:0], py[3:0], px[7:4]};
      else
        vif.rgb = 12'($urandom);
      gx++;
      if (gx >= cur_len) begin
        gx = 0;
        cur_len = HT;
        gy = (gy + 1 == VT) ? 0 : gy + 1;
      end
      @(negedge clk);
    end
  endtask

  task automatic go_to(int x, int y);
    for (int i = 0; i < 3000; i++) begin
      if (gx == x && gy == y) return;
      run(1);
    end
    n_tests++;
    n_fail++;
    $display("FAIL go_to: at %0d,%0d need %0d,%0d", gx, gy, x, y);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, " wr_en"}, 32'(vif.wr_en), 32'd0);
    chk({tag, " wr_x"}, 32'(vif.wr_x), 32'h3FF);
    chk({tag, " wr_y"}, 32'(vif.wr_y), 32'h3FF);
    chk({tag, " wr_data"}, 32'(vif.wr_data), 32'd0);
    chk({tag, " frame_start"}, 32'(vif.frame_start), 32'd0);
    chk({tag, " locked"}, 32'(locked), 32'd0);
    chk({tag, " h_last"}, 32'(h_last), 32'd0);
    chk({tag, " v_last"}, 32'(v_last), 32'd0);
    chk({tag, " err_cnt"}, 32'(err_cnt), 32'd0);
  endtask

  int w0, f0;

  initial begin
    vif.hs = 0; vif.vs = 0; vif.rgb = 0;
    repeat (6) begin
      @(negedge clk);
      vif.hs = 1'($urandom);
      vif.vs = 1'($urandom);
      vif.rgb = 12'($urandom);
      chk_en = 1'b1;
    end
    chk_reset_vals("reset");
    rstn = 1'b1;

    // acquisition: ALIGN frame, lock at the second frame start
    run(HT * VT);
    chk("acq pre-lock", 32'(locked), 32'd0);
    run(1);
    chk("acq locked", 32'(locked), 32'd1);
    chk("acq h_last", 32'(h_last), 32'd23);
    chk("acq v_last", 32'(v_last), 32'd11);
    w0 = wr_cnt; f0 = fs_cnt;
    run(HT * VT);
    chk("frame1 writes", 32'(wr_cnt - w0), 32'(PIX));
    chk("frame1 starts", 32'(fs_cnt - f0), 32'd1);
    chk("pixel (5,3) data", 32'(pin_d), 32'h530);
    w0 = wr_cnt; f0 = fs_cnt;
    run(HT * VT);
    chk("frame2 writes", 32'(wr_cnt - w0), 32'(PIX));
    chk("frame2 starts", 32'(fs_cnt - f0), 32'd1);

    // line glitch: 25-clock line inside the active area
    go_to(0, 5);
    cur_len = HT + 1;
    run(HT + 1);
    run(1);
    chk("glitch h_last", 32'(h_last), 32'd24);
    chk("glitch err_cnt", 32'(err_cnt), 32'd1);
    chk("glitch locked", 32'(locked), 32'd0);
    w0 = wr_cnt;
    go_to(0, 0);
    run(HT * VT);
    chk("glitch no writes", 32'(wr_cnt - w0), 32'd0);
    chk("glitch align", 32'(locked), 32'd0);
    run(1);
    chk("glitch relock", 32'(locked), 32'd1);
    w0 = wr_cnt;
    run(HT * VT);
    chk("relock writes", 32'(wr_cnt - w0), 32'(PIX));

    // stuck sync from the start of line 1
    go_to(0, 1);
    kill = 1;
    run(1000);
    chk("stuck still locked", 32'(locked), 32'd1);
    run(1);
    chk("stuck locked", 32'(locked), 32'd0);
    chk("stuck err_cnt", 32'(err_cnt), 32'd2);
    run(50);
    chk("stuck err once", 32'(err_cnt), 32'd2);
    chk("stuck h_last", 32'(h_last), 32'd23);
    kill = 0; gx = 0; gy = 0; cur_len = HT;
    run(HT * VT);
    run(1);
    chk("stuck relock", 32'(locked), 32'd1);

    // reset in the middle of the active area, pixel (5,4)
    go_to(HL + 5, VP + 4);
    run(1);
    #2 rstn = 1'b0;
    #1 chk_reset_vals("midreset");
    run(3);
    rstn = 1'b1;
    w0 = wr_cnt;
    go_to(0, 0);
    run(HT * VT);
    chk("midreset no writes", 32'(wr_cnt - w0), 32'd0);
    chk("midreset align", 32'(locked), 32'd0);
    run(1);
    chk("midreset relock", 32'(locked), 32'd1);
    w0 = wr_cnt;
    run(HT * VT);
    chk("midreset writes", 32'(wr_cnt - w0), 32'(PIX));
    chk("frame_start at origin", 32'(fs_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
